// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, opcodes,
// datapath select codes and branch funct3 values.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned IMM_W = 3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [IMM_W-1:0] imm_src(input logic [OP_W-1:0] op);
    logic [IMM_W-1:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:         imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch decision from funct3 and the ALU flags of rs1 - rs2.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            zero,
  input  logic            neg,
  input  logic            ovf,
  input  logic            carry,
  output logic            take,
  output logic            bad_funct3
);

  always_comb begin
    take       = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  take = zero;
      F3_BNE:  take = ~zero;
      F3_BLT:  take = neg ^ ovf;
      F3_BGE:  take = ~(neg ^ ovf);
      F3_BLTU: take = ~carry;
      F3_BGEU: take = carry;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core with a bounded memory handshake.
// Define MAINFSM_ILLEGAL_TRAP_EN to trap on illegal opcodes / branch funct3.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OP_W-1:0]   op,
  input  logic [F3_W-1:0]   funct3,
  input  logic              Zero,
  input  logic              Neg,
  input  logic              Ovf,
  input  logic              Carry,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              AdrSrc,
  output logic [SEL_W-1:0]  ALUSrcA,
  output logic [SEL_W-1:0]  ALUSrcB,
  output logic [SEL_W-1:0]  ALUOp,
  output logic [SEL_W-1:0]  ResultSrc,
  output logic [IMM_W-1:0]  ImmSrc,
  output logic              mem_err,
  output logic              illegal,
  output logic              halted
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_err_q;
  logic            mem_err_set;
  logic            take, bad_funct3;
  logic            is_mem_state, expire;
  logic            mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, adr_src_c;
  logic [SEL_W-1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
  logic            illegal_q;
  logic            illegal_set;
`endif

  branch_cond u_branch_cond (
    .funct3     (funct3),
    .zero       (Zero),
    .neg        (Neg),
    .ovf        (Ovf),
    .carry      (Carry),
    .take       (take),
    .bad_funct3 (bad_funct3)
  );

  assign is_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // Expiry fires on the MEM_TIMEOUT-th consecutive wait cycle; ready in that cycle wins.
  assign expire = is_mem_state && !mem_ready && (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALUOP_ADD;
    result_src_c = RES_ALUOUT;
    mem_err_set  = 1'b0;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    illegal_set  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURES;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (expire) begin
          mem_err_set = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
            illegal_set = 1'b1;
            state_d     = S_TRAP;
`else
            state_d     = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (expire) begin
          mem_err_set = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEMWB: begin
        result_src_c = RES_RDATA;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (expire) begin
          mem_err_set = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALUOP_SUB;
        pc_write_c  = take & ~bad_funct3;
        state_d     = S_FETCH;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        if (bad_funct3) begin
          illegal_set = 1'b1;
          state_d     = S_TRAP;
        end
`endif
      end
      S_JALR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_JAL;
      end
      S_JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_UPPER: begin
        alu_src_a_c = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts whenever the state changes or the access completes.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || mem_ready) begin
      cnt_d = '0;
    end else if (is_mem_state) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_q | mem_err_set;
    end
  end

`ifdef MAINFSM_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_q | illegal_set;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Request and enables are held off asynchronously while reset is asserted.
  assign mem_req   = mem_req_c   & reset_n;
  assign MemWrite  = mem_write_c & reset_n;
  assign IRWrite   = ir_write_c  & reset_n;
  assign PCWrite   = pc_write_c  & reset_n;
  assign RegWrite  = reg_write_c & reset_n;
  assign AdrSrc    = adr_src_c;
  assign ALUSrcA   = alu_src_a_c;
  assign ALUSrcB   = alu_src_b_c;
  assign ALUOp     = alu_op_c;
  assign ResultSrc = result_src_c;
  assign ImmSrc    = imm_src(op);
  assign mem_err   = mem_err_q;
  assign halted    = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: per-instruction cycle schedules built from the
// instruction class drive mem_ready and give the expected outputs every cycle.
`timescale 1ns/1ps
module tb_multicycle_main_fsm;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       Zero = 1'b0, Neg = 1'b0, Ovf = 1'b0, Carry = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0] ImmSrc;
  logic       mem_err, illegal, halted;

  multicycle_main_fsm #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .mem_err(mem_err),
    .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
    logic [1:0] a, b, aluop, res;
    logic       halted, err, ill;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   m_err = 1'b0, m_ill = 1'b0;
  int   obs_len, obs_rw, obs_irw, obs_pcw_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] imm_exp(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic cyc_t blank();
    cyc_t e;
    e = '0;
    e.err = m_err;
    e.ill = m_ill;
    return e;
  endfunction

  function automatic cyc_t sel(input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] aluop, input logic [1:0] res);
    cyc_t e;
    e = blank();
    e.a = a; e.b = b; e.aluop = aluop; e.res = res;
    return e;
  endfunction

  task automatic push_trap(input int n);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      e = blank();
      e.halted = 1'b1;
      e.rdy = 1'b1;
      q.push_back(e);
    end
  endtask

  // One memory access lasting `waits` not-ready cycles, or a timeout if that reaches TMO.
  task automatic push_mem(input bit is_fetch, input bit wr, input int waits, output bit to);
    cyc_t e;
    to = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      e = blank();
      e.mem_req = 1'b1;
      e.mem_write = wr;
      e.adr_src = !is_fetch;
      if (is_fetch) begin e.b = 2'b10; e.res = 2'b10; end
      e.rdy = (i == waits);
      if (!e.rdy && i == int'(TMO) - 1) begin
        q.push_back(e);
        m_err = 1'b1;
        to = 1'b1;
        return;
      end
      if (e.rdy && is_fetch) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      q.push_back(e);
    end
  endtask

  task automatic push_wb();
    cyc_t e;
    e = blank();
    e.reg_write = 1'b1;
    q.push_back(e);
  endtask

  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [3:0] fl,
                       input int fw, input int mw);
    cyc_t e;
    bit   to, tk, bad;
    push_mem(1'b1, 1'b0, fw, to);
    if (to) begin push_trap(3); return; end
    q.push_back(sel(2'b01, 2'b01, 2'b00, 2'b00));
    case (o)
      7'b0000011, 7'b0100011: begin
        q.push_back(sel(2'b10, 2'b01, 2'b00, 2'b00));
        push_mem(1'b0, o[5], mw, to);
        if (to) push_trap(3);
        else if (!o[5]) begin
          e = blank(); e.res = 2'b01; e.reg_write = 1'b1; q.push_back(e);
        end
      end
      7'b0110011: begin q.push_back(sel(2'b10, 2'b00, 2'b10, 2'b00)); push_wb(); end
      7'b0010011: begin q.push_back(sel(2'b10, 2'b01, 2'b10, 2'b00)); push_wb(); end
      7'b1101111: begin
        e = sel(2'b01, 2'b10, 2'b00, 2'b00); e.pc_write = 1'b1; q.push_back(e); push_wb();
      end
      7'b1100111: begin
        q.push_back(sel(2'b10, 2'b01, 2'b00, 2'b00));
        e = sel(2'b01, 2'b10, 2'b00, 2'b00); e.pc_write = 1'b1; q.push_back(e); push_wb();
      end
      7'b0110111: begin q.push_back(sel(2'b11, 2'b01, 2'b00, 2'b00)); push_wb(); end
      7'b0010111: begin q.push_back(sel(2'b01, 2'b01, 2'b00, 2'b00)); push_wb(); end
      7'b1100011: begin
        bad = 1'b0;
        case (f3)
          3'b000: tk = fl[3];
          3'b001: tk = !fl[3];
          3'b100: tk = (fl[2] != fl[1]);
          3'b101: tk = (fl[2] == fl[1]);
          3'b110: tk = !fl[0];
          3'b111: tk = fl[0];
          default: begin tk = 1'b0; bad = 1'b1; end
        endcase
        e = sel(2'b10, 2'b00, 2'b01, 2'b00);
        e.pc_write = tk;
        q.push_back(e);
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        if (bad) begin m_ill = 1'b1; push_trap(3); end
`endif
      end
      default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        m_ill = 1'b1;
        push_trap(3);
`endif
      end
    endcase
  endtask

  // Plays the queue one cycle per entry starting at a falling edge.
  task automatic run(input string name);
    cyc_t e;
    int   idx;
    idx = 0;
    obs_len = q.size(); obs_rw = 0; obs_irw = 0; obs_pcw_n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      mem_ready = e.rdy;
      #2;
      check($sformatf("%s cyc%0d outputs", name, idx),
            32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
                 ALUOp, ResultSrc, ImmSrc, halted, mem_err, illegal}),
            32'({e.mem_req, e.mem_write, e.ir_write, e.pc_write, e.reg_write, e.adr_src,
                 e.a, e.b, e.aluop, e.res, imm_exp(op), e.halted, e.err, e.ill}));
      if (RegWrite && obs_rw == 0) obs_rw = idx;
      if (IRWrite && obs_irw == 0) obs_irw = idx;
      if (PCWrite) obs_pcw_n++;
      @(negedge clk);
    end
  endtask

  task automatic instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic [3:0] fl, input int fw, input int mw);
    op = o; funct3 = f3; {Zero, Neg, Ovf, Carry} = fl;
    build(o, f3, fl, fw, mw);
    run(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("reset outputs",
          32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, halted, mem_err, illegal}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_err = 1'b0;
    m_ill = 1'b0;
  endtask

  initial begin
    cyc_t e;
    bit   to;
    @(negedge clk);
    do_reset();

    instr("add", 7'b0110011, 3'b000, 4'b0000, 0, 0);
    check("add cycles", 32'(obs_len), 32'd4);
    check("add IRWrite cycle", 32'(obs_irw), 32'd1);
    check("add RegWrite cycle", 32'(obs_rw), 32'd4);

    instr("lw", 7'b0000011, 3'b010, 4'b0000, 0, 3);
    check("lw cycles", 32'(obs_len), 32'd8);
    check("lw RegWrite cycle", 32'(obs_rw), 32'd8);

    instr("sw", 7'b0100011, 3'b010, 4'b0000, 2, 3);
    check("sw cycles", 32'(obs_len), 32'd9);
    check("sw no RegWrite", 32'(obs_rw), 32'd0);

    instr("addi", 7'b0010011, 3'b000, 4'b0000, 0, 0);
    instr("blt", 7'b1100011, 3'b100, 4'b0100, 0, 0);
    check("blt PCWrite count", 32'(obs_pcw_n), 32'd2);
    check("blt cycles", 32'(obs_len), 32'd3);
    instr("bge", 7'b1100011, 3'b101, 4'b0110, 0, 0);
    check("bge PCWrite count", 32'(obs_pcw_n), 32'd2);
    instr("bgeu", 7'b1100011, 3'b111, 4'b0000, 0, 0);
    check("bgeu PCWrite count", 32'(obs_pcw_n), 32'd1);
    instr("bne", 7'b1100011, 3'b001, 4'b1000, 0, 0);
    check("bne PCWrite count", 32'(obs_pcw_n), 32'd1);
    instr("beq", 7'b1100011, 3'b000, 4'b1000, 0, 0);
    instr("bltu", 7'b1100011, 3'b110, 4'b0000, 0, 0);
    instr("jal", 7'b1101111, 3'b000, 4'b0000, 0, 0);
    check("jal cycles", 32'(obs_len), 32'd4);
    instr("jalr", 7'b1100111, 3'b000, 4'b0000, 1, 0);
    check("jalr cycles", 32'(obs_len), 32'd6);
    instr("lui", 7'b0110111, 3'b000, 4'b0000, 0, 0);
    instr("auipc", 7'b0010111, 3'b000, 4'b0000, 0, 0);

    instr("bad_f3", 7'b1100011, 3'b010, 4'b1000, 0, 0);
    do_reset();

    instr("ill_op", 7'b1111111, 3'b000, 4'b0000, 0, 0);
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    check("ill_op illegal", 32'({illegal, halted}), 32'b11);
`else
    check("ill_op nop cycles", 32'(obs_len), 32'd2);
    check("ill_op not halted", 32'({illegal, halted}), 32'b00);
`endif
    do_reset();

    op = 7'b0100011; funct3 = 3'b010; {Zero, Neg, Ovf, Carry} = 4'b0000;
    push_mem(1'b1, 1'b0, 0, to);
    q.push_back(sel(2'b01, 2'b01, 2'b00, 2'b00));
    q.push_back(sel(2'b10, 2'b01, 2'b00, 2'b00));
    for (int i = 0; i < 2; i++) begin
      e = blank(); e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; q.push_back(e);
    end
    run("sw_rst");
    mem_ready = 1'b0;
    #2;
    check("memwrite wait", 32'({mem_req, MemWrite, AdrSrc}), 32'b111);
    reset_n = 1'b0;
    #1;
    check("reset drops request", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_err = 1'b0; m_ill = 1'b0;
    instr("add_after_rst", 7'b0110011, 3'b000, 4'b0000, 0, 0);
    check("add_after_rst cycles", 32'(obs_len), 32'd4);

    instr("lw_timeout", 7'b0000011, 3'b010, 4'b0000, 0, 9);
    check("lw_timeout no RegWrite", 32'(obs_rw), 32'd0);
    check("lw_timeout status", 32'({mem_err, halted}), 32'b11);
    do_reset();

    instr("fetch_timeout", 7'b0110011, 3'b000, 4'b0000, 10, 0);
    check("fetch_timeout cycles", 32'(obs_len), 32'd7);
    check("fetch_timeout no IRWrite", 32'(obs_irw), 32'd0);
    check("fetch_timeout status", 32'({mem_err, halted}), 32'b11);
    push_trap(5);
    run("trap_hold");
    check("trap_hold no PCWrite", 32'(obs_pcw_n), 32'd0);
    do_reset();
    instr("add_final", 7'b0110011, 3'b000, 4'b0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Control FSM for the multicycle RV32I core. It replaces the single-cycle combinational main decoder and sequences fetch, decode, execute, memory and writeback over several clocks through the shared ALU/memory datapath. It evaluates all six RV32I branch conditions and waits on a ready/valid memory handshake with a bounded timeout. It sits between the instruction register (IR) and the datapath mux and enable controls.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles per memory access. A value of 0 disables the timeout.
- `TO_W`, default 8: width of the wait counter. Must satisfy `MEM_TIMEOUT < 2**TO_W`.

Ports:
- `clk`  in  1  system clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `Zero`, `Neg`, `Ovf`, `Carry`  in  1 each  ALU flags of the current-cycle ALUResult. `Carry` = no-borrow on subtract.
- `mem_ready`  in  1  memory completes the access this cycle.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  store qualifier for `mem_req`.
- `IRWrite`, `PCWrite`, `RegWrite`  out  1 each  register enables.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ALUSrcA`  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- `ALUSrcB`  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4.
- `ALUOp`  out  2  00 add, 01 subtract, 10 decode funct.
- `ResultSrc`  out  2  result select: 00 ALUOut, 01 ReadData, 10 ALUResult.
- `ImmSrc`  out  3  immediate format: I=000, S=001, B=010, J=011, U=100. Combinational from `op` in every state.
- `mem_err`  out  1  sticky; a memory access timed out.
- `illegal`  out  1  sticky; illegal instruction (only when the macro is enabled).
- `halted`  out  1  FSM is in TRAP.

## Operation
All outputs are Moore outputs of the state, except the `mem_ready`-gated enables and the branch `PCWrite`. Undriven selects are 0. States and transitions:
- **FETCH**: `mem_req`, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. On `mem_ready`, pulse `IRWrite` and `PCWrite` and go to DECODE; otherwise hold.
- **DECODE**: A=01, B=01, ALUOp=00 (branch/jal target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - anything else → ILLEGAL handling (see Configuration)
- **MEMADR**: A=10, B=01. Go to MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD**: `mem_req`, AdrSrc=1. On ready → MEMWB.
- **MEMWB**: ResultSrc=01, `RegWrite` → FETCH.
- **MEMWRITE**: `mem_req`, `MemWrite`, AdrSrc=1. On ready → FETCH.
- **EXECR**: A=10, B=00, ALUOp=10 → ALUWB.
- **EXECI**: A=10, B=01, ALUOp=10 → ALUWB.
- **ALUWB**: ResultSrc=00, `RegWrite` → FETCH.
- **BRANCH**: A=10, B=00, ALUOp=01, ResultSrc=00. `PCWrite` = take → FETCH. Take condition by funct3:
  - 000: Zero
  - 001: !Zero
  - 100: Neg^Ovf
  - 101: !(Neg^Ovf)
  - 110: !Carry
  - 111: Carry
  - 010/011: illegal
- **JALR**: A=10, B=01 (target into ALUOut) → JAL. Clearing bit 0 of the target is done in the datapath.
- **JAL**: A=01, B=10, ResultSrc=00, `PCWrite` → ALUWB (rd = OldPC+4).
- **UPPER**: A=11 for lui, 01 for auipc (op[5] selects); B=01 → ALUWB.
- **TRAP**: all enables 0, `halted`=1. Left only by reset.

Memory timeout:
- The wait counter clears on entry to each memory state and increments every cycle without `mem_ready`.
- When the counter reaches `MEM_TIMEOUT` without ready: set `mem_err`, go to TRAP, and assert no write enable.
- If `mem_ready` arrives in the same cycle as expiry, ready wins.

## Timing
- Zero-wait cycle counts per instruction:
  - lw: 5
  - sw, R-type, I-type, jal, lui, auipc: 4
  - jalr: 5
  - branch: 3
- Each memory wait cycle adds one cycle.
- `mem_req`, `AdrSrc` and `MemWrite` stay stable until the cycle in which `mem_ready` is seen.
- Reset: state=FETCH, counter=0, `mem_err`=`illegal`=0. While `reset_n` is low, `mem_req`, `MemWrite`, `IRWrite`, `PCWrite` and `RegWrite` are forced to 0 asynchronously.
- Reset mid-instruction abandons it with no partial write. The first `mem_req` comes in the first cycle after release.

## Configuration
- `MAINFSM_ILLEGAL_TRAP_EN` defined: an unknown opcode, or branch funct3 010/011, sets `illegal` and goes to TRAP.
- Undefined: the instruction is treated as a NOP (DECODE/BRANCH → FETCH, no enables), and `illegal` is tied to 0.

## Structure
- Package `riscv_ctrl_pkg` holds: the state enum, opcode constants, ImmSrc/ALUSrcA/ALUSrcB/ResultSrc/ALUOp encodings, and branch funct3 constants.
- Sub-module `branch_cond` is combinational: funct3 and the four flags in; `take` and `bad_funct3` out.

## Test plan
- `add` with `mem_ready` tied high → states FETCH, DECODE, EXECR, ALUWB; `RegWrite` high only in cycle 4; `IRWrite` only in cycle 1.
- `lw` with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with `mem_req` and AdrSrc=1 stable; MEMWB follows; 8 cycles total.
- Branch matrix:
  - blt, Neg=1, Ovf=0 → `PCWrite`=1
  - bge, Neg=1, Ovf=1 → `PCWrite`=1
  - bgeu, Carry=0 → `PCWrite`=0
  - bne, Zero=1 → `PCWrite`=0
- `MEM_TIMEOUT`=4, `mem_ready` never asserted → `mem_err`=1 after 4 FETCH wait cycles; `halted`=1; no `IRWrite`; TRAP held until reset.
- op=7'b1111111:
  - macro defined → `illegal`=1, `halted`=1
  - undefined → back to FETCH after DECODE with no enables
- `reset_n` low during MEMWRITE wait → `MemWrite` and `mem_req` drop the same instant; after release, FETCH asserts `mem_req`.
